// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start, data (LSB first), optional parity and
// stop bit periods, one CLK cycle per bit period, and drives the Tx mux select.
// Latency: request accepted in IDLE -> START on the next cycle; frame is
// DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
// Backpressure: a request is taken only in IDLE; Data_Valid is ignored while busy,
// so a held request gets one IDLE cycle between frames.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-high reset, aborts any frame in progress
//   P_DATA     in   parallel payload, latched on acceptance
//   Data_Valid in   send request
//   PAR_EN     in   append parity bit (latched on acceptance)
//   PAR_TYP    in   0 even / 1 odd parity (latched on acceptance)
//   mux_sel    out  00 start, 01 stop/idle, 10 data, 11 parity
//   ser_data   out  current payload bit (latched bit 0 outside DATA)
//   par_bit    out  parity of the latched payload
//   busy       out  high for the whole frame
//
// Build option: define UART_TX_PARITY_EN to compile in the PARITY state and parity
// logic. Without it PAR_EN/PAR_TYP are ignored and par_bit is tied to 0.

module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    // A one-bit payload still needs a one-bit counter register.
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_q, par_d;
`else
    logic unused_par_cfg;
    assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            data_q    <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_q     <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_d     = par_q;
`endif
        mux_sel   = 2'b01;
        busy      = 1'b1;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (Data_Valid) begin
                    state_d = START;
                    data_d  = P_DATA;
`ifdef UART_TX_PARITY_EN
                    par_en_d = PAR_EN;
                    // Parity is computed once here so it stays frozen until the
                    // next acceptance, independent of later input changes.
                    par_d    = (^P_DATA) ^ PAR_TYP;
`endif
                end
            end
            START: begin
                mux_sel   = 2'b00;
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: begin
                mux_sel = 2'b10;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d   = par_en_q ? PARITY : STOP;
`else
                    state_d   = STOP;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                mux_sel = 2'b11;
                state_d = STOP;
            end
`endif
            STOP: begin
                mux_sel = 2'b01;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Outside DATA the mux ignores ser_data; parking it on bit 0 keeps it deterministic.
    assign ser_data = (state_q == DATA) ? data_q[bit_cnt_q] : data_q[0];

`ifdef UART_TX_PARITY_EN
    assign par_bit = par_q;
`else
    assign par_bit = 1'b0;
`endif

endmodule
